// File: rtl/pio_pwm_pkg.sv
// Shared types and constants for the PIO-driven PWM generator.
// The period is 255 steps, numbered 0..PWM_LAST_STEP.
package pio_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    localparam int unsigned   PWM_DUTY_W    = 8;
    localparam logic [7:0]    PWM_LAST_STEP = 8'd254;

    // Prescaler counter width; a 1-cycle prescale still needs one flop bit.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/pio_pwm_driver_if.sv
// Bundle between the PIO register side and the PWM driver.
// The PIO drives duty/enable; the driver returns the waveform and status.
interface pio_pwm_driver_if;

    logic [pio_pwm_pkg::PWM_DUTY_W-1:0] duty_in;
    logic                               enable;
    logic                               pwm_out;
    logic                               period_start;
    logic [pio_pwm_pkg::PWM_DUTY_W-1:0] duty_active;

    modport master (
        output duty_in,
        output enable,
        input  pwm_out,
        input  period_start,
        input  duty_active
    );

    modport slave (
        input  duty_in,
        input  enable,
        output pwm_out,
        output period_start,
        output duty_active
    );

endinterface

// File: rtl/pio_pwm_driver_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while run is high, ticks on the last count.
// Dropping run clears the count so every run starts on a full prescale interval.
module pwm_prescaler
    import pio_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned      CNT_W    = prescale_width(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        tick       = run && (count_reg == CNT_LAST);
        count_next = count_reg;
        if (!run || tick) begin
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/pio_pwm_driver.sv
// PWM driver: 255-step periods, duty sampled from the PIO only at period boundaries.
// Every output is a flop, so duty_in/enable never reach the pins combinationally.
module pio_pwm_driver
    import pio_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 50
) (
    input  logic               clk,
    input  logic               reset,
    pio_pwm_driver_if.slave    bus
);

    pwm_state_e              state_reg;
    pwm_state_e              state_next;
    logic [PWM_DUTY_W-1:0]   step_reg;
    logic [PWM_DUTY_W-1:0]   step_next;
    logic [PWM_DUTY_W-1:0]   duty_reg;
    logic [PWM_DUTY_W-1:0]   duty_next;
    logic                    pwm_reg;
    logic                    pwm_next;
    logic                    start_reg;
    logic                    start_next;

    logic                    run;
    logic                    tick;
    logic                    wrap;

    // Gating with enable lets the prescaler clear on the same edge that leaves RUN.
    assign run  = (state_reg == RUN) && bus.enable;
    assign wrap = tick && (step_reg == PWM_LAST_STEP);

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        duty_next  = duty_reg;
        start_next = 1'b0;
        pwm_next   = (state_reg == RUN) && (step_reg < duty_reg);

        case (state_reg)
            IDLE: begin
                if (bus.enable) begin
                    state_next = RUN;
                    step_next  = '0;
                    duty_next  = bus.duty_in;
                    start_next = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    // duty_active deliberately holds so software can read the last value.
                    state_next = IDLE;
                    step_next  = '0;
                end else if (wrap) begin
                    step_next  = '0;
                    duty_next  = bus.duty_in;
                    start_next = 1'b1;
                end else if (tick) begin
                    step_next  = step_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_reg  <= '0;
            duty_reg  <= '0;
            pwm_reg   <= 1'b0;
            start_reg <= 1'b0;
        end else begin
            step_reg  <= step_next;
            duty_reg  <= duty_next;
            pwm_reg   <= pwm_next;
            start_reg <= start_next;
        end
    end

    assign bus.pwm_out      = pwm_reg;
    assign bus.period_start = start_reg;
    assign bus.duty_active  = duty_reg;

endmodule

// File: tb/tb_pio_pwm_driver.sv
// Randomised scoreboard bench: two drivers (PRESCALE 2 and 1) share one stimulus stream
// and are checked cycle by cycle and period by period against an elapsed-time model.
module tb_pio_pwm_driver;

    typedef struct packed {
        logic       pwm;
        logic       ps;
        logic [7:0] duty;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] duty_in = 8'd0;

    logic       pwm_w  [2];
    logic       ps_w   [2];
    logic [7:0] duty_w [2];
    int         done_cnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int P      = (gi == 0) ? 2 : 1;
        localparam int PERIOD = 255 * P;

        pio_pwm_driver_if bus ();
        assign bus.duty_in = duty_in;
        assign bus.enable  = enable;

        pio_pwm_driver #(
            .PRESCALE (P)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        assign pwm_w[gi]  = bus.pwm_out;
        assign ps_w[gi]   = bus.period_start;
        assign duty_w[gi] = bus.duty_active;

        exp_t exp_q[$];
        int   per_q[$];
        bit   run_m = 1'b0;
        int   t_m = 0;
        int   duty_m = 0;

        // Reference: position in the period is elapsed run time, step = (t / P) mod 255.
        always @(posedge clk) begin : model
            exp_t e;
            e = '0;
            if (reset) begin
                run_m  = 1'b0;
                t_m    = 0;
                duty_m = 0;
                per_q.delete();
            end else begin
                e.pwm = run_m && (((t_m / P) % 255) < duty_m);
                if (enable && !run_m) begin
                    run_m  = 1'b1;
                    t_m    = 0;
                    duty_m = int'(duty_in);
                    e.ps   = 1'b1;
                    per_q.push_back(duty_m);
                end else if (enable && run_m) begin
                    t_m++;
                    if (t_m % PERIOD == 0) begin
                        duty_m = int'(duty_in);
                        e.ps   = 1'b1;
                        per_q.push_back(duty_m);
                    end
                end else if (!enable && run_m) begin
                    run_m = 1'b0;
                    t_m   = 0;
                    if (per_q.size() > 0) per_q[per_q.size()-1] = -1;
                end
            end
            e.duty = duty_m[7:0];
            exp_q.push_back(e);
        end

        bit ps_prev = 1'b0;
        bit win_open = 1'b0;
        int win_len = 0;
        int win_high = 0;
        initial done_cnt[gi] = 0;

        always @(negedge clk) begin : monitor
            exp_t e;
            int   d;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (reset) e = '0;
                check($sformatf("p%0d_pwm_out", P), int'(bus.pwm_out), int'(e.pwm));
                check($sformatf("p%0d_period_start", P), int'(bus.period_start), int'(e.ps));
                check($sformatf("p%0d_duty_active", P), int'(bus.duty_active), int'(e.duty));
            end
            if (reset) begin
                ps_prev  = 1'b0;
                win_open = 1'b0;
            end else begin
                // Waveform lags period_start by one cycle, so windows open one cycle late.
                if (ps_prev) begin
                    if (win_open && per_q.size() > 0) begin
                        d = per_q.pop_front();
                        if (d >= 0) begin
                            check($sformatf("p%0d_period_len", P), win_len, PERIOD);
                            check($sformatf("p%0d_high_cycles", P), win_high, d * P);
                            done_cnt[gi]++;
                            $display("[P=%0d] period duty=%0d high=%0d len=%0d", P, d, win_high, win_len);
                        end
                    end
                    win_open = 1'b1;
                    win_len  = 0;
                    win_high = 0;
                end
                if (win_open) begin
                    win_len++;
                    win_high += int'(bus.pwm_out);
                end
                ps_prev = bus.period_start;
            end
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [7:0] d);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable  = 1'b1;
        duty_in = d;
    endtask

    // Asserted away from the clock edge; outputs must already be low before any edge.
    task automatic pulse_reset(input int hold, input bit drop_enable);
        @(posedge clk);
        #2;
        reset = 1'b1;
        if (drop_enable) enable = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_pwm_out", int'(pwm_w[i]), 0);
            check("async_rst_period_start", int'(ps_w[i]), 0);
            check("async_rst_duty_active", int'(duty_w[i]), 0);
        end
        repeat (hold) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         n;

        run_cycles(3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_cycles(5);

        // Duty 128 for three periods.
        @(negedge clk);
        enable  = 1'b1;
        duty_in = 8'd128;
        run_cycles(3 * 510 + 10);

        // Duty change mid-period only takes effect at the wrap.
        restart(8'd64);
        run_cycles(100);
        duty_in = 8'd192;
        run_cycles(2 * 510 + 20);

        // Extremes: never high, always high.
        restart(8'd0);
        run_cycles(3 * 510 + 10);
        restart(8'd255);
        run_cycles(3 * 510 + 10);

        // Drop enable around step 10, then re-enable with duty 32.
        restart(8'd200);
        run_cycles(21);
        enable = 1'b0;
        @(negedge clk);
        enable  = 1'b1;
        duty_in = 8'd32;
        run_cycles(2 * 510 + 10);

        // Duty 1: single high cycle per period on the PRESCALE=1 instance.
        restart(8'd1);
        run_cycles(2 * 510 + 10);

        // Reset mid-run with duty 128; must stay idle until enable rises again.
        restart(8'd128);
        run_cycles(300);
        pulse_reset(3, 1'b1);
        run_cycles(40);
        enable = 1'b1;
        run_cycles(600);

        for (int s = 0; s < 24; s++) begin
            case ($urandom_range(0, 4))
                0:       d = 8'd0;
                1:       d = 8'd255;
                2:       d = 8'd1;
                default: d = 8'($urandom_range(0, 255));
            endcase
            duty_in = d;
            enable  = ($urandom_range(0, 9) != 0);
            n = $urandom_range(1, 1200);
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if ($urandom_range(0, 99) == 0) duty_in = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 7) == 0) pulse_reset($urandom_range(1, 4), 1'b0);
        end

        enable = 1'b0;
        run_cycles(5);
        for (int i = 0; i < 2; i++) begin
            check("completed_periods", int'(done_cnt[i] >= 8), 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_pwm_driver.md
PIO_PWM_DRIVER -- requirements
Module: pio_pwm_driver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: PRESCALE, default 50, clk cycles per PWM step (legal range 1..65535).
REQ-003 Port: clk  input  1  system clock, rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: duty_in  input  8  requested duty, driven by the 8-bit output PIO out_port.
REQ-006 Port: enable  input  1  run request, level-sensitive, synchronous to clk.
REQ-007 Port: pwm_out  output  1  registered PWM waveform.
REQ-008 Port: period_start  output  1  one-cycle pulse marking the first step of each PWM period.
REQ-009 Port: duty_active  output  8  duty value in use for the current period.

Function
REQ-010 The FSM SHALL have two states: IDLE and RUN.
REQ-011 In IDLE with enable=1 at a clk edge, the FSM SHALL enter RUN and load duty_active<=duty_in, step counter<=0, prescaler<=0.
REQ-012 In RUN with enable=0 at a clk edge, the FSM SHALL enter IDLE and clear the step counter and prescaler; duty_active holds its value.
REQ-013 The prescaler SHALL count 0..PRESCALE-1 in RUN and assert an internal tick when it equals PRESCALE-1, then wrap to 0.
REQ-014 On tick, the step counter SHALL increment through 0..254 and wrap 254->0; one period = 255*PRESCALE clk cycles.
REQ-015 On the 254->0 wrap, duty_active SHALL load duty_in; duty_in changes at any other time SHALL NOT affect the current period.
REQ-016 pwm_out SHALL be a flop equal to (state==RUN and step<duty_active) from the previous cycle (latency 1 clk).
REQ-017 duty 0 SHALL give pwm_out constantly 0; duty 255 SHALL give pwm_out constantly 1 in RUN; duty N SHALL give N*PRESCALE high cycles per period.
REQ-018 period_start SHALL pulse high for exactly one cycle, the cycle after entry into RUN and the cycle after each 254->0 wrap.
REQ-019 In IDLE, pwm_out and period_start SHALL be 0 one cycle after IDLE is entered.
REQ-020 enable toggled 1->0->1 on consecutive edges SHALL restart a fresh period with a new duty_in sample.
REQ-021 PRESCALE=1 SHALL tick every RUN cycle with no dead cycle at wrap.

Reset
REQ-022 While reset=1, state SHALL be IDLE, and step counter, prescaler, duty_active, pwm_out, and period_start SHALL all be 0, independent of clk.
REQ-023 Reset asserted mid-period SHALL force pwm_out low immediately; after release, the block SHALL start a new period only via REQ-011.

Structure
REQ-024 Package pio_pwm_pkg SHALL hold the state enum (IDLE, RUN) and constant PWM_LAST_STEP=254.
REQ-025 The prescaler SHALL be a sub-module pwm_prescaler (inputs clk, reset, run; output tick) with counter width $clog2(PRESCALE) (minimum 1).
REQ-026 All state SHALL reside in clk-domain flops; there SHALL be no combinational path from duty_in or enable to any output.

Verification (PRESCALE=2 unless stated)
REQ-027 reset pulse mid-RUN with duty 128 -> pwm_out, period_start, and duty_active are 0 while reset=1, and the block stays IDLE after release until enable rises.
REQ-028 enable=1, duty_in=128 -> period_start pulse at cycle 1, pwm_out high for 256 cycles then low for 254 cycles, period 510 cycles.
REQ-029 duty_in 0 then 255 (separate runs) -> pwm_out constantly 0 and constantly 1 across 3 full periods.
REQ-030 duty_in changed 64->192 mid-period -> current period keeps 128 high cycles, next period (after period_start) has 384 high cycles, duty_active updates exactly at the wrap.
REQ-031 enable dropped at step 10 -> pwm_out 0 one cycle later; re-enable with duty 32 -> new period with 64 high cycles from step 0.
REQ-032 PRESCALE=1, duty 1 -> pwm_out high exactly 1 cycle per 255-cycle period, and period_start spacing is 255 cycles.
